// File: rtl/id_ex_dump.sv
// Snapshots the ID/EX pipeline register on request and streams it out byte by byte.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte to every frame.
module id_ex_dump #(
  parameter int unsigned INST_SZ = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dump_req,
  input  logic               i_halt,
  input  logic               i_alu_src,
  input  logic               i_reg_dst,
  input  logic               i_jal_sel,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic               i_bds_sel,
  input  logic [2:0]         i_alu_op,
  input  logic [2:0]         i_bhw,
  input  logic [INST_SZ-1:0] i_bds,
  input  logic [INST_SZ-1:0] i_read_data_1,
  input  logic [INST_SZ-1:0] i_read_data_2,
  input  logic [INST_SZ-1:0] i_instr_imm,
  input  logic [4:0]         i_instr_rt,
  input  logic [4:0]         i_instr_rd,
  input  logic [4:0]         i_instr_rs,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned WordBytes = INST_SZ / 8;
  localparam int unsigned BaseBytes = 5 + 4 * WordBytes;
`ifdef DUMP_CHECKSUM_EN
  localparam int unsigned NumBytes  = BaseBytes + 1;
`else
  localparam int unsigned NumBytes  = BaseBytes;
`endif
  localparam int unsigned IdxW      = $clog2(NumBytes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [BaseBytes*8-1:0]   snap_q, snap_d;
  logic [7:0]               byte_sel;

  // Byte 0 sits in the least-significant position so byte i is snap_q[8*i +: 8].
  logic [BaseBytes*8-1:0] capture;
  assign capture = {3'b000, i_instr_rs, 3'b000, i_instr_rd, 3'b000, i_instr_rt,
                    i_instr_imm, i_read_data_2, i_read_data_1, i_bds,
                    i_bds_sel, i_alu_op, 1'b0, i_bhw,
                    i_halt, i_alu_src, i_reg_dst, i_jal_sel,
                    i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg};

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] cksum;
  always_comb begin
    cksum = 8'h00;
    for (int unsigned i = 0; i < BaseBytes; i++) begin
      cksum = cksum ^ snap_q[8*i +: 8];
    end
  end
`endif

  always_comb begin
    byte_sel = 8'h00;
    for (int unsigned i = 0; i < BaseBytes; i++) begin
      if (idx_q == IdxW'(i)) begin
        byte_sel = snap_q[8*i +: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    if (idx_q == LastIdx) begin
      byte_sel = cksum;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    unique case (state_q)
      StIdle: begin
        if (i_dump_req) begin
          snap_d  = capture;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_tx_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign o_tx_valid = (state_q == StSend);
  assign o_busy     = (state_q == StSend);
  assign o_done     = (state_q == StDone);
  assign o_tx_data  = (state_q == StSend) ? byte_sel : 8'h00;

endmodule
